// File: rtl/myadc_axil_slave.sv
// AXI4-Lite register slave for the ADC IP: four RW config registers, sample and status readback.
// Define MYADC_SAMPLE_FIFO_EN to buffer samples in a FIFO_DEPTH-entry FIFO instead of one holding register.
module myadc_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned SAMPLE_WIDTH       = 12,
  parameter int unsigned FIFO_DEPTH         = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]         sample_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   adc_ctrl
);

  localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = DW / 8;
  localparam logic [2:0]  IDX_SAMPLE = 3'd4;
  localparam logic [2:0]  IDX_STATUS = 3'd5;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam int unsigned unused_depth = FIFO_DEPTH;

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [DW-1:0]     w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              aw_held, w_held;
  logic [DW-1:0]     regs [4];
  logic              ovf;

  logic aw_hs, w_hs, ar_hs, commit;
  logic aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic [2:0] aw_idx, ar_idx;
  logic wr_err, rd_err, ovf_clr, ovf_set, pop, present;
  logic [SAMPLE_WIDTH-1:0] head;
  logic [3:0] count_field;
  logic [DW-1:0] rd_data;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held & w_held;

  assign aw_idx = aw_addr_q[4:2];
  assign ar_idx = S_AXI_ARADDR[4:2];
  assign wr_err = aw_idx[2] & (aw_idx != IDX_STATUS);
  assign rd_err = ar_idx[2] & ar_idx[1];
  assign ovf_clr = commit & (aw_idx == IDX_STATUS) & w_strb_q[0] & w_data_q[0];
  assign pop     = ar_hs & (ar_idx == IDX_SAMPLE) & present;

  assign aw_held_n = commit ? 1'b0 : (aw_held | aw_hs);
  assign w_held_n  = commit ? 1'b0 : (w_held | w_hs);
  assign bvalid_n  = commit | (S_AXI_BVALID & ~S_AXI_BREADY);
  assign rvalid_n  = ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY);

  assign adc_ctrl = regs[0];

  // Read mux sampled at AR accept, so a same-cycle write is not yet visible
  always_comb begin
    rd_data = '0;
    case (ar_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = regs[ar_idx[1:0]];
      IDX_SAMPLE: begin
        rd_data[DW-1] = present;
        if (present) rd_data[SAMPLE_WIDTH-1:0] = head;
      end
      IDX_STATUS: rd_data[7:0] = {count_field, 2'b00, present, ovf};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
      ovf           <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      S_AXI_AWREADY <= ~aw_held_n & ~bvalid_n;
      S_AXI_WREADY  <= ~w_held_n & ~bvalid_n;
      S_AXI_BVALID  <= bvalid_n;
      if (commit) begin
        S_AXI_BRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!aw_idx[2]) begin
          for (int b = 0; b < STRB_W; b++)
            if (w_strb_q[b]) regs[aw_idx[1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
      S_AXI_ARREADY <= ~rvalid_n;
      S_AXI_RVALID  <= rvalid_n;
      if (ar_hs) begin
        S_AXI_RDATA <= rd_data;
        S_AXI_RRESP <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
      // A new overflow wins over a same-cycle W1C
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef MYADC_SAMPLE_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr, fill;
  logic full, push;

  assign fill        = wr_ptr - rd_ptr;
  assign full        = (fill == (PTR_W+1)'(FIFO_DEPTH));
  assign present     = (fill != '0);
  assign push        = sample_valid & (~full | pop);
  assign ovf_set     = sample_valid & full & ~pop;
  assign head        = mem[rd_ptr[PTR_W-1:0]];
  assign count_field = 4'(fill);

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= sample_data;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end
`else
  logic [SAMPLE_WIDTH-1:0] hold_q;
  logic                    present_q;

  assign present     = present_q;
  assign head        = hold_q;
  assign ovf_set     = sample_valid & present_q & ~pop;
  assign count_field = {3'b000, present_q};

  // A sample arriving with a same-cycle read replaces the popped one
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      hold_q    <= '0;
      present_q <= 1'b0;
    end else if (sample_valid) begin
      hold_q    <= sample_data;
      present_q <= 1'b1;
    end else if (pop) begin
      present_q <= 1'b0;
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], aw_addr_q[1:0]};

endmodule

// File: doc/myadc_axil_slave.md
# myadc_axil_slave

AXI4-Lite responder for the ADC IP: decodes master accesses into four read/write configuration registers and read-only sample/status registers fed by the ADC capture path. Sits behind the block-design AXI interconnect port S00_AXI; the AXI VIP master drives it in simulation, the PS drives it in hardware.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes word offsets 0x00–0x1C
- SAMPLE_WIDTH, 12, ADC sample width
- FIFO_DEPTH, 8, sample FIFO entries (power of two; used only with MYADC_SAMPLE_FIFO_EN)
- S_AXI_ACLK  in  1  single clock; all logic on rising edge
- S_AXI_ARESETN  in  1  reset; synchronous, active-low
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
- sample_valid  in  1  one-cycle strobe, new ADC sample
- sample_data  in  SAMPLE_WIDTH  ADC sample, valid with strobe
- adc_ctrl  out  32  contents of REG0 (ADC enable/config to capture logic)

## Operation
- Register map (word-aligned, AWADDR/ARADDR[1:0] ignored): 0x00 REG0, 0x04 REG1, 0x08 REG2, 0x0C REG3 (all RW, reset 0); 0x10 SAMPLE (RO); 0x14 STATUS (bit0 overflow sticky, W1C; bit1 sample available; bits[7:4] FIFO count); 0x18/0x1C unmapped.
- Writes: AW and W accepted independently, each captured into a holding register; write commits in the cycle both are held. WSTRB[n] enables byte n. Write to RO/unmapped: no state change, BRESP=SLVERR (2'b10); else OKAY.
- Reads: SAMPLE returns {sample-present bit31, zeros, sample[SAMPLE_WIDTH-1:0]}; bit31=0 and data 0 when empty. Unmapped read: RDATA=0, RRESP=SLVERR.
- Read of SAMPLE pops one entry at the R handshake commit (AR accept cycle), never on a re-presented RDATA.
- Sample arrival with FIFO full: sample dropped, overflow set. Push and pop same cycle while full: both occur, no overflow.
- Write W1C of overflow in same cycle as new overflow: overflow stays set.

## Timing
- Reset (ARESETN low at clock edge): AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; REG0–REG3, FIFO pointers, overflow = 0; adc_ctrl = 0. Outstanding transactions discarded.
- AWREADY/WREADY high when the respective holding register is empty and BVALID low; drop for the cycle after their handshake.
- BVALID asserts the cycle after commit; held with BRESP stable until BREADY. No new AW/W accepted while BVALID high.
- ARREADY high when RVALID low. RVALID asserts the cycle after AR handshake (read latency 1); RDATA/RRESP stable until RREADY.
- Read and write to the same register in the same cycle: read returns pre-write value.
- adc_ctrl updates the cycle after REG0 commit.
- One outstanding write and one outstanding read max; read and write channels operate concurrently.

## Configuration
- MYADC_SAMPLE_FIFO_EN defined: FIFO_DEPTH-entry sample FIFO as above.
- Undefined: single sample holding register; new sample overwrites it, sets overflow if previous unread; SAMPLE read clears present flag; STATUS count field reads 0 or 1.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x00/0x04/0x08/0x0C, read back -> 0x00000001..0x00000004, all BRESP/RRESP OKAY; adc_ctrl=0x00000001.
- WDATA presented 3 cycles before AWADDR, BREADY low 5 cycles -> single commit, BVALID held stable 5 cycles, no second AW/W accepted.
- Write 0xAABBCCDD to REG1 with WSTRB=4'b0101 over 0x11223344 -> read 0x11BB33DD.
- Push samples 0x001..0x009 (FIFO_DEPTH=8), read SAMPLE ×9 -> 0x80000001..0x80000008 then 0x00000000; STATUS bit0=1; write 0x1 to STATUS -> bit0=0.
- Write 0x0 to 0x10 and read 0x18 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, FIFO unchanged.
- Deassert ARESETN during BVALID wait -> next cycle BVALID=0, REG0–REG3=0, subsequent write/read completes normally.
